dram_cmd_arbiter: RTL

DRAM_CMD_ARBITER -- requirements
Module: dram_cmd_arbiter

---
 rtl/dram_cmd_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_arbiter.sv
// Arbitrates a write-request queue and a read-request queue onto one MIG user port, one command at a time.
// Pops are combinational in IDLE; read data returns 1 cycle after app_rd_data_valid; rdata_s has no backpressure.
module dram_cmd_arbiter #(
  parameter int RD_OUTST = 4
) (
  input  logic         mclk,
  input  logic         mrst_n,
  input  logic         wreq_valid,
  input  logic [27:0]  wreq_addr,
  input  logic [127:0] wreq_data,
  input  logic [15:0]  wreq_mask,
  output logic         wreq_pop,
  input  logic         rreq_valid,
  input  logic [3:0]   rreq_id,
  input  logic [27:0]  rreq_addr,
  output logic         rreq_pop,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic [15:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic         app_rd_data_end,
  output logic         rdata_s_valid,
  output logic [3:0]   rdata_s_id,
  output logic [127:0] rdata_s_data
);
  localparam int PW = $clog2(RD_OUTST);
  localparam int CW = $clog2(RD_OUTST) + 1;
  localparam logic [CW-1:0] OUT_MAX = CW'(RD_OUTST);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, state_nxt;

  logic [27:0]   addr_q;
  logic [127:0]  data_q;
  logic [15:0]   mask_q;
  logic [3:0]    id_q;
  logic          cmd_done, dat_done, cmd_done_nxt, dat_done_nxt;
  logic          last_rd;
  logic [CW-1:0] outst;
  logic [PW-1:0] wptr, rptr;
  logic [3:0]    id_fifo [RD_OUTST];
  logic          w_elig, r_elig, grant_w, grant_r;
  logic          cmd_acc, dat_acc, rd_push, rd_pop;
  logic          unused_end;

  assign unused_end = app_rd_data_end;

  // Pops are gated by reset so every output is quiet while mrst_n is low.
  always_comb begin
    w_elig  = wreq_valid;
    r_elig  = rreq_valid && (outst < OUT_MAX);
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (state == IDLE && mrst_n) begin
      if (w_elig && r_elig) begin
        grant_w = (wreq_addr[27:4] == rreq_addr[27:4]) || last_rd;
        grant_r = !grant_w;
      end else begin
        grant_w = w_elig;
        grant_r = r_elig;
      end
    end
  end

  assign wreq_pop    = grant_w;
  assign rreq_pop    = grant_r;
  assign app_wdf_end = app_wdf_wren;
  assign rd_pop      = app_rd_data_valid && (outst != '0);

  always_comb begin
    state_nxt    = state;
    cmd_done_nxt = cmd_done;
    dat_done_nxt = dat_done;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    cmd_acc      = 1'b0;
    dat_acc      = 1'b0;
    rd_push      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_w)      state_nxt = WR;
        else if (grant_r) state_nxt = RD;
      end
      WR: begin
        app_en       = !cmd_done;
        app_wdf_wren = !dat_done;
        app_addr     = addr_q;
        app_wdf_data = data_q;
        app_wdf_mask = mask_q;
        cmd_acc      = app_en && app_rdy;
        dat_acc      = app_wdf_wren && app_wdf_rdy;
        if ((cmd_done || cmd_acc) && (dat_done || dat_acc)) begin
          state_nxt    = IDLE;
          cmd_done_nxt = 1'b0;
          dat_done_nxt = 1'b0;
        end else begin
          cmd_done_nxt = cmd_done || cmd_acc;
          dat_done_nxt = dat_done || dat_acc;
        end
      end
      RD: begin
        app_en   = 1'b1;
        app_cmd  = 3'b001;
        app_addr = addr_q;
        if (app_rdy) begin
          rd_push   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state         <= IDLE;
      cmd_done      <= 1'b0;
      dat_done      <= 1'b0;
      last_rd       <= 1'b1;
      outst         <= '0;
      wptr          <= '0;
      rptr          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      id_q          <= '0;
      rdata_s_valid <= 1'b0;
      rdata_s_id    <= '0;
      rdata_s_data  <= '0;
    end else begin
      state    <= state_nxt;
      cmd_done <= cmd_done_nxt;
      dat_done <= dat_done_nxt;
      if (grant_w) begin
        addr_q  <= wreq_addr;
        data_q  <= wreq_data;
        mask_q  <= wreq_mask;
        last_rd <= 1'b0;
      end else if (grant_r) begin
        addr_q  <= rreq_addr;
        id_q    <= rreq_id;
        last_rd <= 1'b1;
      end
      if (rd_push) wptr <= wptr + PW'(1);
      if (rd_pop)  rptr <= rptr + PW'(1);
      if (rd_push && !rd_pop)      outst <= outst + CW'(1);
      else if (!rd_push && rd_pop) outst <= outst - CW'(1);
      rdata_s_valid <= rd_pop;
      if (rd_pop) begin
        rdata_s_id   <= id_fifo[rptr];
        rdata_s_data <= app_rd_data;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rd_push) id_fifo[wptr] <= id_q;
  end
endmodule
